// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze game datapath.
//   - dir_e        : direction codes carried on move/dir buses
//   - kr_state_e   : state encoding of the key_repeat controller
//   - TICKS_PER_MS : system-clock ticks per millisecond at 10 MHz
//   - helper functions for one-hot button vectors
// No ports (package).
// -----------------------------------------------------------------------------
package maze_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [2:0] {
      KR_IDLE     = 3'd0,
      KR_DEB_ARM  = 3'd1,
      KR_DEB_WAIT = 3'd2,
      KR_FIRE     = 3'd3,
      KR_REP_ARM  = 3'd4,
      KR_REP_WAIT = 3'd5,
      KR_REL_WAIT = 3'd6
   } kr_state_e;

   localparam int TICKS_PER_MS = 10000;

   // True when exactly one bit of the button vector is set
   function automatic logic isOneHot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Index of the set bit of a one-hot button vector
   function automatic dir_e oneHotIndex(input logic [3:0] v);
      dir_e d;
      d = DIR_UP;
      if (v[1]) d = DIR_DOWN;
      if (v[2]) d = DIR_LEFT;
      if (v[3]) d = DIR_RIGHT;
      return d;
   endfunction

   // Button pattern that corresponds to holding only direction d
   function automatic logic [3:0] dirToOneHot(input dir_e d);
      return 4'd1 << d;
   endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for asynchronous level inputs.
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset, clears both stages
//   i_d    : asynchronous input vector (WIDTH bits)
//   o_q    : synchronized vector, two clocks after i_d
// -----------------------------------------------------------------------------
module sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // First stage may go metastable; second stage gives it a full cycle to settle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/key_repeat.sv
// -----------------------------------------------------------------------------
// key_repeat
// Turns the four raw direction buttons into debounced one-cycle move pulses,
// with optional hold-to-repeat. All timing is delegated to an external delay
// block: this controller loads it through o_delay_set/o_delay_ms and waits for
// i_delay_free.
// Configuration macro: KEY_AUTOREPEAT_EN
//   defined   -> holding a button repeats (FIRST_MS, then every REPEAT_MS)
//   undefined -> exactly one move per press, waits for full release
// Ports:
//   i_clk        : 10 MHz system clock
//   i_rst        : synchronous active-high reset
//   i_btn[3:0]   : raw buttons, bit0 up, bit1 down, bit2 left, bit3 right
//   o_move       : one-cycle move pulse
//   o_dir[1:0]   : direction of the last move (held between pulses)
//   o_delay_set  : one-cycle load strobe to the delay block
//   o_delay_ms   : interval for the delay block, valid with o_delay_set
//   i_delay_free : delay block idle flag
// -----------------------------------------------------------------------------
module key_repeat
   import maze_pkg::*;
#(
   parameter logic [7:0] DEBOUNCE_MS = 8'd20,
   parameter logic [7:0] FIRST_MS    = 8'd250,
   parameter logic [7:0] REPEAT_MS   = 8'd100
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_btn,
   output logic       o_move,
   output logic [1:0] o_dir,
   output logic       o_delay_set,
   output logic [7:0] o_delay_ms,
   input  logic       i_delay_free
);

   logic [3:0] w_bs;
   kr_state_e  r_state;
   kr_state_e  w_nextState;
   dir_e       r_dirQ;
   dir_e       w_dirQNext;
   dir_e       r_dir;
   logic       r_move;
   logic       r_delaySet;
   logic [7:0] r_delayMs;
   logic       w_held;
   logic [7:0] w_delayMsNext;
`ifdef KEY_AUTOREPEAT_EN
   logic       r_firstDone;
`endif

   sync2 #(.WIDTH(4)) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_btn),
      .o_q   (w_bs)
   );

   // The latched button is still the only one pressed
   assign w_held = (w_bs == dirToOneHot(r_dirQ));

   // Next-state logic; the output strobes are derived from the state being
   // entered so that they are registered and line up with ARM/FIRE cycles
   always_comb begin
      w_nextState   = r_state;
      w_dirQNext    = r_dirQ;
      w_delayMsNext = 8'd0;
      case (r_state)
         KR_IDLE: begin
            if (isOneHot(w_bs)) begin
               w_dirQNext  = oneHotIndex(w_bs);
               w_nextState = KR_DEB_ARM;
            end
         end
         KR_DEB_ARM:  w_nextState = KR_DEB_WAIT;
         KR_DEB_WAIT: begin
            if (!w_held)           w_nextState = KR_IDLE;
            else if (i_delay_free) w_nextState = KR_FIRE;
         end
`ifdef KEY_AUTOREPEAT_EN
         KR_FIRE:     w_nextState = KR_REP_ARM;
         KR_REP_ARM:  w_nextState = KR_REP_WAIT;
         KR_REP_WAIT: begin
            if (!w_held)           w_nextState = KR_IDLE;
            else if (i_delay_free) w_nextState = KR_FIRE;
         end
`else
         KR_FIRE:     w_nextState = KR_REL_WAIT;
`endif
         KR_REL_WAIT: begin
            if (w_bs == 4'd0) w_nextState = KR_IDLE;
         end
         default:     w_nextState = KR_IDLE;
      endcase

      if (w_nextState == KR_DEB_ARM) w_delayMsNext = DEBOUNCE_MS;
`ifdef KEY_AUTOREPEAT_EN
      if (w_nextState == KR_REP_ARM) w_delayMsNext = r_firstDone ? REPEAT_MS : FIRST_MS;
`endif
   end

   // State register plus registered output strobes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= KR_IDLE;
         r_dirQ     <= DIR_UP;
         r_dir      <= DIR_UP;
         r_move     <= 1'b0;
         r_delaySet <= 1'b0;
         r_delayMs  <= 8'd0;
      end else begin
         r_state    <= w_nextState;
         r_dirQ     <= w_dirQNext;
         r_move     <= (w_nextState == KR_FIRE);
         r_delaySet <= (w_nextState == KR_DEB_ARM) || (w_nextState == KR_REP_ARM);
         r_delayMs  <= w_delayMsNext;
         if (w_nextState == KR_FIRE) r_dir <= r_dirQ;
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   // First repeat after a fresh debounce uses the longer FIRST_MS hold time
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_firstDone <= 1'b0;
      end else if (w_nextState == KR_DEB_ARM) begin
         r_firstDone <= 1'b0;
      end else if (w_nextState == KR_REP_ARM) begin
         r_firstDone <= 1'b1;
      end
   end
`endif

   assign o_move      = r_move;
   assign o_dir       = r_dir;
   assign o_delay_set = r_delaySet;
   assign o_delay_ms  = r_delayMs;

endmodule

// File: tb/tb_key_repeat.sv
// -----------------------------------------------------------------------------
// tb_key_repeat
// Directed bench for key_repeat. Two instances: one with the default intervals
// and one with all intervals zero. The external delay block is modelled here
// at a reduced scale of K cycles per ms (free low for ms*K cycles after the
// load edge) so that millisecond scenarios stay short.
// -----------------------------------------------------------------------------
module tb_key_repeat;

   localparam int K = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rstZ = 1'b1;
   logic [3:0] btn = 4'd0;
   logic [3:0] btnZ = 4'd0;

   logic       move, delaySet, free;
   logic [1:0] dir;
   logic [7:0] delayMs;
   logic       moveZ, delaySetZ, freeZ;
   logic [1:0] dirZ;
   logic [7:0] delayMsZ;

   int cnt = 0;
   int cntZ = 0;
   int moveCount = 0;
   int moveCountZ = 0;
   int setCount = 0;
   logic prevMove = 1'b0;
   logic prevMoveZ = 1'b0;
   logic overlap = 1'b0;
   logic wide = 1'b0;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   key_repeat #(.DEBOUNCE_MS(8'd20), .FIRST_MS(8'd250), .REPEAT_MS(8'd100)) dut (
      .i_clk(clk), .i_rst(rst), .i_btn(btn), .o_move(move), .o_dir(dir),
      .o_delay_set(delaySet), .o_delay_ms(delayMs), .i_delay_free(free)
   );

   key_repeat #(.DEBOUNCE_MS(8'd0), .FIRST_MS(8'd0), .REPEAT_MS(8'd0)) dutZ (
      .i_clk(clk), .i_rst(rstZ), .i_btn(btnZ), .o_move(moveZ), .o_dir(dirZ),
      .o_delay_set(delaySetZ), .o_delay_ms(delayMsZ), .i_delay_free(freeZ)
   );

   // Scaled stand-ins for the delay blocks
   always @(posedge clk) begin
      if (delaySet) cnt <= int'(delayMs) * K;
      else if (cnt != 0) cnt <= cnt - 1;
      if (delaySetZ) cntZ <= int'(delayMsZ) * K;
      else if (cntZ != 0) cntZ <= cntZ - 1;
   end
   assign free  = (cnt == 0);
   assign freeZ = (cntZ == 0);

   // Pulse bookkeeping and sticky protocol-violation flags
   always @(negedge clk) begin
      if (move === 1'b1) moveCount++;
      if (moveZ === 1'b1) moveCountZ++;
      if (delaySet === 1'b1) setCount++;
      if ((move === 1'b1 && delaySet === 1'b1) || (moveZ === 1'b1 && delaySetZ === 1'b1)) overlap = 1'b1;
      if ((move === 1'b1 && prevMove) || (moveZ === 1'b1 && prevMoveZ)) wide = 1'b1;
      prevMove  = (move === 1'b1);
      prevMoveZ = (moveZ === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [3:0] b);
      btn = b;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int base;
      int sbase;
      int elapsed;
      int exp4 [5];
      exp4 = '{85, 1088, 1491, 1894, 2297};

      // Reset held with a button down: everything stays quiet
      applyStimulus(4'b0001);
      repeat (3) begin
         tick(1);
         checkOutput("reset_outputs", {20'd0, move, dir, delaySet, delayMs}, 32'd0);
      end
      rst = 1'b0;
      rstZ = 1'b0;
      tick(2);
      checkOutput("reset_no_early_set", {31'd0, delaySet}, 32'd0);
      tick(1);
      checkOutput("reset_first_set", {23'd0, delaySet, delayMs}, {23'd0, 1'b1, 8'd20});
      applyStimulus(4'b0000);
      tick(10);

      // Clean press on LEFT
      $display("[TB] clean press");
      base = moveCount;
      applyStimulus(4'b0100);
      tick(84);
      checkOutput("clean_no_early", moveCount, base);
      tick(1);
      checkOutput("clean_move", {29'd0, move, dir}, {29'd0, 1'b1, 2'd2});
      tick(1);
      checkOutput("clean_one_cycle", {31'd0, move}, 32'd0);
      tick(34);
      applyStimulus(4'b0000);
      tick(1200);
      checkOutput("clean_single", moveCount, base + 1);

      // Bouncing UP button
      $display("[TB] bounce");
      base = moveCount;
      applyStimulus(4'b0001); tick(20);
      applyStimulus(4'b0000); tick(20);
      applyStimulus(4'b0001); tick(20);
      applyStimulus(4'b0000); tick(20);
      applyStimulus(4'b0001);
      tick(84);
      checkOutput("bounce_no_early", moveCount, base);
      tick(1);
      checkOutput("bounce_move", {29'd0, move, dir}, {29'd0, 1'b1, 2'd0});
      tick(10);
      applyStimulus(4'b0000);
      tick(20);

      // Long hold on RIGHT
      $display("[TB] hold");
      base = moveCount;
      applyStimulus(4'b1000);
`ifdef KEY_AUTOREPEAT_EN
      elapsed = 0;
      for (int i = 0; i < 5; i++) begin
         tick(exp4[i] - 1 - elapsed);
         checkOutput("hold_count_before", moveCount, base + i);
         tick(1);
         checkOutput("hold_move", {29'd0, move, dir}, {29'd0, 1'b1, 2'd3});
         tick(1);
         checkOutput("hold_rep_arm", {23'd0, delaySet, delayMs},
                     {23'd0, 1'b1, (i == 0) ? 8'd250 : 8'd100});
         elapsed = exp4[i] + 1;
      end
      tick(2400 - elapsed);
      applyStimulus(4'b0000);
      tick(10);
      checkOutput("hold_total", moveCount, base + 5);
`else
      tick(84);
      checkOutput("hold_count_before", moveCount, base);
      tick(1);
      checkOutput("hold_move", {29'd0, move, dir}, {29'd0, 1'b1, 2'd3});
      tick(1);
      checkOutput("hold_no_rearm", {23'd0, delaySet, delayMs}, 32'd0);
      tick(2400 - 86);
      applyStimulus(4'b0000);
      tick(10);
      checkOutput("hold_total", moveCount, base + 1);
`endif
      applyStimulus(4'b1000);
      tick(85);
      checkOutput("repress_move", {29'd0, move, dir}, {29'd0, 1'b1, 2'd3});
      tick(5);
      applyStimulus(4'b0000);
      tick(10);

      // Two buttons, then DOWN alone
      $display("[TB] two buttons");
      base = moveCount;
      sbase = setCount;
      applyStimulus(4'b0011);
      tick(200);
      checkOutput("two_no_move", moveCount, base);
      checkOutput("two_no_set", setCount, sbase);
      applyStimulus(4'b0010);
      tick(3);
      checkOutput("two_arm", {23'd0, delaySet, delayMs}, {23'd0, 1'b1, 8'd20});
      tick(81);
      checkOutput("two_no_early", moveCount, base);
      tick(1);
      checkOutput("two_move", {29'd0, move, dir}, {29'd0, 1'b1, 2'd1});
      tick(5);
      applyStimulus(4'b0000);
      tick(10);

      // Zero intervals on the second instance
      $display("[TB] zero intervals");
      base = moveCountZ;
      btnZ = 4'b0001;
      tick(4);
      checkOutput("zero_no_early", moveCountZ, base);
      tick(1);
      checkOutput("zero_move0", {29'd0, moveZ, dirZ}, {29'd0, 1'b1, 2'd0});
`ifdef KEY_AUTOREPEAT_EN
      tick(1);
      checkOutput("zero_arm", {23'd0, delaySetZ, delayMsZ}, {23'd0, 1'b1, 8'd0});
      tick(2);
      checkOutput("zero_move1", {31'd0, moveZ}, 32'd1);
      tick(3);
      checkOutput("zero_move2", {31'd0, moveZ}, 32'd1);
      tick(2);
      rstZ = 1'b1;
      tick(1);
      checkOutput("zero_rst_stop", {30'd0, moveZ, delaySetZ}, 32'd0);
      tick(5);
      checkOutput("zero_total", moveCountZ, base + 3);
`else
      tick(1);
      checkOutput("zero_no_rearm", {30'd0, moveZ, delaySetZ}, 32'd0);
      tick(7);
      rstZ = 1'b1;
      tick(1);
      checkOutput("zero_rst_stop", {30'd0, moveZ, delaySetZ}, 32'd0);
      tick(5);
      checkOutput("zero_total", moveCountZ, base + 1);
`endif
      btnZ = 4'b0000;

      checkOutput("no_move_set_overlap", {31'd0, overlap}, 32'd0);
      checkOutput("move_one_cycle_wide", {31'd0, wide}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
